// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the dmem arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_NIC  = 2'b10
    } owner_e;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 64;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with clear (clear wins over increment)
module arb_sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority dmem arbiter with bounded NIC wait; optional stats via DMEM_ARB_STATS_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NIC_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_memEn,
    input  logic              cpu_memWrEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              nic_req,
    input  logic              nic_wr,
    input  logic [ADDR_W-1:0] nic_addr,
    input  logic [DATA_W-1:0] nic_wdata,
    output logic              nic_gnt,
    output logic              nic_rvalid,
    output logic [DATA_W-1:0] nic_rdata,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [31:0]       stat_cpu_stall_cnt,
    output logic [31:0]       stat_nic_grant_cnt,
`endif
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(NIC_MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt;
    owner_e                rd_owner;
    logic                  nic_wins;
    logic                  cpu_wins;

    // Grant logic is gated by rst so reset forces all memory controls low.
    always_comb begin
        nic_wins = rst && nic_req && (!cpu_memEn || (wait_cnt == WAIT_MAX));
        cpu_wins = rst && cpu_memEn && !nic_wins;
    end

    always_comb begin
        mem_en    = nic_wins || cpu_wins;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (nic_wins) begin
            mem_wr_en = nic_wr;
            mem_addr  = nic_addr;
            mem_wdata = nic_wdata;
        end else if (cpu_wins) begin
            mem_wr_en = cpu_memWrEn;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign nic_gnt   = nic_wins;
    assign cpu_stall = cpu_memEn && nic_wins;
    assign cpu_rdata = mem_rdata;
    assign nic_rdata = mem_rdata;

    arb_sat_counter #(
        .WIDTH (WAIT_CNT_W),
        .MAX   (WAIT_MAX)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (nic_req && !nic_wins),
        .clr   (nic_wins || !nic_req),
        .count (wait_cnt)
    );

    // Owner of the read data arriving next cycle; writes and idle cycles clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner <= OWN_NONE;
        end else if (nic_wins && !nic_wr) begin
            rd_owner <= OWN_NIC;
        end else if (cpu_wins && !cpu_memWrEn) begin
            rd_owner <= OWN_CPU;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign nic_rvalid = (rd_owner == OWN_NIC);

`ifdef DMEM_ARB_STATS_EN
    arb_sat_counter #(
        .WIDTH (32)
    ) u_stat_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (cpu_stall),
        .clr   (stat_clr),
        .count (stat_cpu_stall_cnt)
    );

    arb_sat_counter #(
        .WIDTH (32)
    ) u_stat_gnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (nic_gnt),
        .clr   (stat_clr),
        .count (stat_nic_grant_cnt)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a queue/array reference model
module tb_dmem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 64;
    localparam int MAXW = 4;

    typedef struct {
        logic          gnt;
        logic          stall;
        logic          en;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } ctl_t;

    typedef struct {
        int            due;
        logic          is_nic;
        logic [DW-1:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_memEn, cpu_memWrEn;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          nic_req, nic_wr;
    logic [AW-1:0] nic_addr;
    logic [DW-1:0] nic_wdata;
    logic          nic_gnt, nic_rvalid;
    logic [DW-1:0] nic_rdata;
    logic          mem_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic          stat_clr = 1'b0;
    logic [31:0]   stat_cpu_stall_cnt, stat_nic_grant_cnt;
    int            ref_stall_cnt = 0;
    int            ref_gnt_cnt = 0;
`endif
    logic          clr_req = 1'b0;

    logic [DW-1:0] env_mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    ctl_t          ctl_q[$];
    rd_t           rd_q[$];
    int            wref = 0;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic          mon_en = 1'b0;
    logic          done = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .NIC_MAX_WAIT (MAXW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_memEn   (cpu_memEn),
        .cpu_memWrEn (cpu_memWrEn),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_stall   (cpu_stall),
        .cpu_rdata   (cpu_rdata),
        .nic_req     (nic_req),
        .nic_wr      (nic_wr),
        .nic_addr    (nic_addr),
        .nic_wdata   (nic_wdata),
        .nic_gnt     (nic_gnt),
        .nic_rvalid  (nic_rvalid),
        .nic_rdata   (nic_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_clr           (stat_clr),
        .stat_cpu_stall_cnt (stat_cpu_stall_cnt),
        .stat_nic_grant_cnt (stat_nic_grant_cnt),
`endif
        .mem_en      (mem_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Input-registered single-port memory standing in for dmem.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr_en) env_mem[mem_addr] <= mem_wdata;
            else           mem_rdata <= env_mem[mem_addr];
        end
    end

    // One request cycle: drive inputs, then predict the outcome from the arbitration rules.
    task automatic drive_cycle(input logic ce, input logic cw, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, input logic nr, input logic nw,
                               input logic [AW-1:0] na, input logic [DW-1:0] nd,
                               output logic nwon, output logic stalled);
        ctl_t e;
        rd_t  r;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        cyc++;
        cpu_memEn = ce; cpu_memWrEn = cw; cpu_addr = ca; cpu_wdata = cd;
        nic_req = nr; nic_wr = nw; nic_addr = na; nic_wdata = nd;
        nwon = nr && (!ce || wref == MAXW);
        stalled = ce && nwon;
        e.gnt = nwon;
        e.stall = stalled;
        e.en = nr || ce;
        e.wr = nwon ? nw : (ce && cw);
        e.addr = nwon ? na : (ce ? ca : '0);
        e.wdata = nwon ? nd : cd;
        ctl_q.push_back(e);
        if (nwon || ce) begin
            if (nwon ? nw : cw) begin
                ref_mem[e.addr] = e.wdata;
            end else begin
                r.due = cyc + 1;
                r.is_nic = nwon;
                r.data = ref_mem[e.addr];
                rd_q.push_back(r);
            end
        end
        if (nwon || !nr) wref = 0;
        else if (wref < MAXW) wref = wref + 1;
`ifdef DMEM_ARB_STATS_EN
        stat_clr = clr_req;
        if (clr_req) begin
            ref_stall_cnt = 0;
            ref_gnt_cnt = 0;
        end else begin
            if (stalled) ref_stall_cnt++;
            if (nwon) ref_gnt_cnt++;
        end
`endif
        clr_req = 1'b0;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the queued predictions each cycle.
    initial begin
        ctl_t e;
        rd_t  r;
        forever begin
            @(negedge clk);
            #2;
            if (done) begin
                chk("ctl_q_drained", 64'(ctl_q.size()), 64'd0);
                chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
`ifdef DMEM_ARB_STATS_EN
                chk("stat_stall", 64'(stat_cpu_stall_cnt), 64'(ref_stall_cnt));
                chk("stat_gnt", 64'(stat_nic_grant_cnt), 64'(ref_gnt_cnt));
`endif
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end else if (!rst) begin
                chk("reset_forced", 64'({mem_en, mem_wr_en, nic_gnt, cpu_stall, nic_rvalid}), 64'd0);
                chk("reset_addr", 64'(mem_addr), 64'd0);
            end else if (mon_en) begin
                if (ctl_q.size() == 0) begin
                    chk("ctl_underflow", 64'd1, 64'd0);
                end else begin
                    e = ctl_q.pop_front();
                    chk("grant", 64'({nic_gnt, cpu_stall}), 64'({e.gnt, e.stall}));
                    chk("mem_ctl", 64'({mem_en, mem_wr_en}), 64'({e.en, e.wr}));
                    if (e.en) chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.en && e.wr) chk("mem_wdata", mem_wdata, e.wdata);
                end
                if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                    r = rd_q.pop_front();
                    chk("nic_rvalid", 64'(nic_rvalid), 64'(r.is_nic));
                    if (r.is_nic) chk("nic_rdata", nic_rdata, r.data);
                    else          chk("cpu_rdata", cpu_rdata, r.data);
                end else begin
                    chk("nic_rvalid_idle", 64'(nic_rvalid), 64'd0);
                end
            end
        end
    end

    initial begin
        logic          nwon, stl, npend, chold;
        logic          ce, cw, nw;
        logic [AW-1:0] ca, na;
        logic [DW-1:0] cd, nd;
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        env_mem[16'h0010] = 64'hDEADBEEF_00000001;
        ref_mem[16'h0010] = 64'hDEADBEEF_00000001;

        // Reset with both requesting; released inside the first drive_cycle.
        cpu_memEn = 1'b1; cpu_memWrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        nic_req = 1'b1; nic_wr = 1'b0; nic_addr = '0; nic_wdata = '0;
        @(negedge clk);
        drive_cycle(1, 0, 16'h0001, '0, 1, 0, 16'h0002, '0, nwon, stl);
        drive_cycle(0, 0, '0, '0, 1, 0, 16'h0002, '0, nwon, stl);

        // CPU-only read of preloaded word
        drive_cycle(1, 0, 16'h0010, '0, 0, 0, '0, '0, nwon, stl);
        drive_cycle(0, 0, '0, '0, 0, 0, '0, '0, nwon, stl);

        // Contention: NIC must win on the fifth contested cycle
        clr_req = 1'b1;
        drive_cycle(0, 0, '0, '0, 0, 0, '0, '0, nwon, stl);
        npend = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1, 0, AW'(i), '0, npend, 1, 16'h0030, 64'hA5A5_0000_0000_0030, nwon, stl);
            if (nwon) npend = 1'b0;
        end

        // NIC write then CPU read of same address
        drive_cycle(0, 0, '0, '0, 1, 1, 16'h0020, 64'h1234, nwon, stl);
        drive_cycle(1, 0, 16'h0020, '0, 0, 0, '0, '0, nwon, stl);

        // Alternating NIC/CPU reads, no bubbles
        ref_mem[16'h0004] = ref_mem[16'h0004];
        drive_cycle(1, 1, 16'h0004, 64'h0404_0404_0404_0404, 0, 0, '0, '0, nwon, stl);
        drive_cycle(1, 1, 16'h0008, 64'h0808_0808_0808_0808, 0, 0, '0, '0, nwon, stl);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 0, '0, '0, 1, 0, 16'h0004, '0, nwon, stl);
            drive_cycle(1, 0, 16'h0008, '0, 0, 0, '0, '0, nwon, stl);
        end

        // Randomized traffic with protocol-respecting holds
        npend = 1'b0; chold = 1'b0;
        ce = 0; cw = 0; ca = '0; cd = '0; nw = 0; na = '0; nd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!chold) begin
                ce = ($urandom_range(0, 9) < 6);
                cw = $urandom_range(0, 1) == 1;
                ca = AW'($urandom_range(0, 15));
                cd = {$urandom, $urandom};
            end
            if (!npend && $urandom_range(0, 2) == 0) begin
                npend = 1'b1;
                nw = $urandom_range(0, 1) == 1;
                na = AW'($urandom_range(0, 15));
                nd = {$urandom, $urandom};
            end
            if (i == 300) clr_req = 1'b1;
            drive_cycle(ce, cw, ca, cd, npend, nw, na, nd, nwon, stl);
            if (nwon) npend = 1'b0;
            chold = stl;
        end
        drive_cycle(0, 0, '0, '0, 0, 0, '0, '0, nwon, stl);

        // Reset during a granted NIC read squashes the return
        drive_cycle(0, 0, '0, '0, 1, 0, 16'h0004, '0, nwon, stl);
        #3;
        rst = 1'b0;
        mon_en = 1'b0;
        cpu_memEn = 1'b0;
        nic_req = 1'b0;
        ctl_q.delete();
        rd_q.delete();
        wref = 0;
`ifdef DMEM_ARB_STATS_EN
        ref_stall_cnt = 0;
        ref_gnt_cnt = 0;
`endif
        repeat (3) @(negedge clk);
        drive_cycle(0, 0, '0, '0, 0, 0, '0, '0, nwon, stl);
        drive_cycle(1, 0, 16'h0004, '0, 1, 0, 16'h0008, '0, nwon, stl);
        drive_cycle(0, 0, '0, '0, 1, 0, 16'h0008, '0, nwon, stl);
        drive_cycle(0, 0, '0, '0, 0, 0, '0, '0, nwon, stl);

        @(negedge clk);
        mon_en = 1'b0;
        done = 1'b1;
    end

endmodule
